// File: rtl/neuron_chunk_sequencer.sv
// neuron_chunk_sequencer
//   Feeds a LANES-wide binary-weight dot-product unit. Serial neuron bytes and
//   weight words are packed into a chunk, the chunk is held on the operand
//   outputs while the unit computes, and the returned signed partial sums are
//   accumulated with saturation over num_chunks_i chunks. One activated
//   output neuron is emitted per start_i.
//
//   Optional feature macro: NEURON_RELU_EN (defined: ReLU on out_data_o).
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   start_i, num_chunks_i  begin one neuron; chunk count sampled with start
//   in_valid_i/in_ready_o/in_data_i   neuron byte stream
//   w_valid_i/w_ready_o/w_bits_i      weight word stream
//   mult_neurons_o, mult_weights_o    operands to the dot-product unit
//   mult_sum_i                        signed partial sum from the unit
//   out_valid_o/out_ready_i           result handshake
//   out_data_o, out_acc_o             activated neuron, raw accumulator
//   busy_o                            high outside IDLE
module neuron_chunk_sequencer #(
  parameter int unsigned LANES    = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned ACC_W    = 16,
  parameter int unsigned MULT_LAT = 1,
  parameter int unsigned CW       = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [CW-1:0]         num_chunks_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DW-1:0]         in_data_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [LANES-1:0]      w_bits_i,
  output logic [LANES*DW-1:0]   mult_neurons_o,
  output logic [LANES-1:0]      mult_weights_o,
  input  logic [DW-1:0]         mult_sum_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DW-1:0]         out_data_o,
  output logic [ACC_W-1:0]      out_acc_o,
  output logic                  busy_o
);

  localparam int unsigned BCW = $clog2(LANES + 1);
  localparam int unsigned LW  = 3;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, OUT} state_e;

  state_e               state_q, state_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                 w_have_q, w_have_d;
  logic [LW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [CW-1:0]        chunk_cnt_q, chunk_cnt_d;
  logic [CW-1:0]        num_q, num_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [LANES*DW-1:0]  neur_q, neur_d;
  logic [LANES-1:0]     wts_q, wts_d;
  logic                 out_valid_q, out_valid_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic [ACC_W-1:0]     out_acc_q, out_acc_d;

  logic                 in_fire, w_fire, sample, last_chunk;
  logic                 bytes_done, w_done;
  logic [ACC_W:0]       sum_ext;
  logic [ACC_W-1:0]     acc_sat;
  logic [DW-1:0]        clipped, activated;

  // Handshake decode: registered state and counters only.
  always_comb begin
    in_ready_o = (state_q == LOAD) && (byte_cnt_q < BCW'(LANES));
    w_ready_o  = (state_q == LOAD) && !w_have_q;
    busy_o     = (state_q != IDLE);
    in_fire    = in_valid_i && in_ready_o;
    w_fire     = w_valid_i && w_ready_o;
    // Chunk complete counts the acceptances happening this very cycle.
    bytes_done = (byte_cnt_q == BCW'(LANES)) ||
                 ((byte_cnt_q == BCW'(LANES - 1)) && in_fire);
    w_done     = w_have_q || w_fire;
    sample     = (state_q == ISSUE) && (lat_cnt_q == LW'(MULT_LAT));
    last_chunk = ((CW+1)'(chunk_cnt_q) + (CW+1)'(1)) == (CW+1)'(num_q);
  end

  // Saturating accumulate of the sign-extended partial sum.
  always_comb begin
    sum_ext = {acc_q[ACC_W-1], acc_q} +
              {{(ACC_W+1-DW){mult_sum_i[DW-1]}}, mult_sum_i};
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
      acc_sat = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_sat = sum_ext[ACC_W-1:0];
    end
  end

  // Clip to signed DW range, then activation.
  always_comb begin
    if (!acc_q[ACC_W-1] && (acc_q[ACC_W-2:DW-1] != '0)) begin
      clipped = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_q[ACC_W-1] && (acc_q[ACC_W-2:DW-1] != '1)) begin
      clipped = {1'b1, {(DW-1){1'b0}}};
    end else begin
      clipped = acc_q[DW-1:0];
    end
`ifdef NEURON_RELU_EN
    activated = clipped[DW-1] ? '0 : clipped;
`else
    activated = clipped;
`endif
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (num_chunks_i == '0) ? OUT : LOAD;
      LOAD:    if (bytes_done && w_done) state_d = ISSUE;
      ISSUE:   if (sample) state_d = last_chunk ? OUT : LOAD;
      OUT:     if (out_valid_q && out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    w_have_d    = w_have_q;
    lat_cnt_d   = lat_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    num_d       = num_q;
    acc_d       = acc_q;
    neur_d      = neur_q;
    wts_d       = wts_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_d       = '0;
          byte_cnt_d  = '0;
          w_have_d    = 1'b0;
          chunk_cnt_d = '0;
          lat_cnt_d   = '0;
          num_d       = num_chunks_i;
        end
      end
      LOAD: begin
        lat_cnt_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (in_fire && (byte_cnt_q == BCW'(k))) begin
            neur_d[k*DW +: DW] = in_data_i;
          end
        end
        if (in_fire) byte_cnt_d = byte_cnt_q + BCW'(1);
        if (w_fire) begin
          wts_d    = w_bits_i;
          w_have_d = 1'b1;
        end
      end
      ISSUE: begin
        if (sample) begin
          acc_d       = acc_sat;
          chunk_cnt_d = chunk_cnt_q + CW'(1);
          byte_cnt_d  = '0;
          w_have_d    = 1'b0;
          lat_cnt_d   = '0;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      OUT: begin
        // First OUT cycle registers the result from the settled accumulator.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_acc_d   = acc_q;
          out_data_d  = activated;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q  <= '0;
      w_have_q    <= 1'b0;
      lat_cnt_q   <= '0;
      chunk_cnt_q <= '0;
      num_q       <= '0;
      acc_q       <= '0;
      neur_q      <= '0;
      wts_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      w_have_q    <= w_have_d;
      lat_cnt_q   <= lat_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      num_q       <= num_d;
      acc_q       <= acc_d;
      neur_q      <= neur_d;
      wts_q       <= wts_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
    end
  end

  always_comb begin
    mult_neurons_o = neur_q;
    mult_weights_o = wts_q;
    out_valid_o    = out_valid_q;
    out_data_o     = out_data_q;
    out_acc_o      = out_acc_q;
  end

endmodule

// File: tb/tb_neuron_chunk_sequencer.sv
module tb_neuron_chunk_sequencer;

  localparam int LANES    = 16;
  localparam int DW       = 8;
  localparam int ACC_W    = 16;
  localparam int MULT_LAT = 1;
  localparam int CW       = 7;

`ifdef NEURON_RELU_EN
  localparam logic [7:0] NEG_E0 = 8'h00;
  localparam logic [7:0] NEG_80 = 8'h00;
`else
  localparam logic [7:0] NEG_E0 = 8'hE0;
  localparam logic [7:0] NEG_80 = 8'h80;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  start_i;
  logic [CW-1:0]         num_chunks_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DW-1:0]         in_data_i;
  logic                  w_valid_i;
  logic                  w_ready_o;
  logic [LANES-1:0]      w_bits_i;
  logic [LANES*DW-1:0]   mult_neurons_o;
  logic [LANES-1:0]      mult_weights_o;
  logic [DW-1:0]         ms_q = '0;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DW-1:0]         out_data_o;
  logic [ACC_W-1:0]      out_acc_o;
  logic                  busy_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  neuron_chunk_sequencer #(
    .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .MULT_LAT(MULT_LAT), .CW(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .num_chunks_i(num_chunks_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_bits_i(w_bits_i),
    .mult_neurons_o(mult_neurons_o), .mult_weights_o(mult_weights_o),
    .mult_sum_i(ms_q), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_acc_o(out_acc_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Dot-product unit model with one cycle of latency.
  int dp;
  always_comb begin
    logic signed [DW-1:0] nk;
    dp = 0;
    for (int k = 0; k < LANES; k++) begin
      nk = mult_neurons_o[k*DW +: DW];
      dp = dp + (mult_weights_o[k] ? int'(nk) : -int'(nk));
    end
  end
  always @(posedge clk_i) ms_q <= dp[DW-1:0];

  typedef struct {
    int           n;
    logic [7:0]   b;
    logic [7:0]   bl;
    logic [15:0]  w;
    bit           gaps;
    int           wmode;   // 0: weight with first byte, 1: weight first, 2: weight with last byte
    logic [15:0]  exp_acc;
    logic [7:0]   exp_data;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic feed_chunk(input vec_t v, inout int nb, inout int nw);
    int bi = 0;
    bit wd = 1'b0;
    int guard = 0;
    while ((bi < LANES || !wd) && guard < 500) begin
      guard++;
      in_data_i = (bi == LANES - 1) ? v.bl : v.b;
      w_bits_i  = v.w;
      case (v.wmode)
        1: begin
          w_valid_i  = 1'b1;
          in_valid_i = wd && (!v.gaps || $urandom_range(0, 2) != 0);
        end
        2: begin
          in_valid_i = !v.gaps || $urandom_range(0, 2) != 0;
          w_valid_i  = (bi == LANES - 1) && in_valid_i;
        end
        default: begin
          w_valid_i  = 1'b1;
          in_valid_i = !v.gaps || $urandom_range(0, 2) != 0;
        end
      endcase
      if (in_valid_i && in_ready_o) begin bi++; nb++; end
      if (w_valid_i && w_ready_o) begin wd = 1'b1; nw++; end
      @(negedge clk_i);
    end
  endtask

  task automatic run_vec(input vec_t v, input int hold, input string tag);
    int  nb = 0;
    int  nw = 0;
    int  t0;
    bit  seen = 1'b0;
    num_chunks_i = CW'(v.n);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    t0 = cyc;
    for (int c = 0; c < v.n; c++) feed_chunk(v, nb, nw);
    in_valid_i  = 1'b0;
    w_valid_i   = 1'b0;
    out_ready_i = (hold == 0);
    for (int g = 0; g < 3000 && !seen; g++) begin
      if (out_valid_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    check({tag, "_out_valid_seen"}, 128'(seen), 128'(1));
    if (!seen) begin
      out_ready_i = 1'b1;
      return;
    end
    check({tag, "_out_acc"}, 128'(out_acc_o), 128'(v.exp_acc));
    check({tag, "_out_data"}, 128'(out_data_o), 128'(v.exp_data));
    check({tag, "_bytes_accepted"}, 128'(nb), 128'(v.n * LANES));
    check({tag, "_weights_accepted"}, 128'(nw), 128'(v.n));
    if (!v.gaps && v.wmode == 0)
      check({tag, "_latency"}, 128'(cyc - t0), 128'(v.n * (LANES + MULT_LAT + 1) + 1));
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_stable"},
            128'({out_valid_o, in_ready_o, busy_o, out_acc_o, out_data_o}),
            128'({1'b1, 1'b0, 1'b1, v.exp_acc, v.exp_data}));
      start_i = (i == 1);
      @(negedge clk_i);
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check({tag, "_valid_busy_fall"}, 128'({out_valid_o, busy_o}), 128'(0));
  endtask

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1, 8'h01, 8'h01, 16'hFFFF, 1'b0, 0, 16'h0010, 8'h10};
    tbl[1] = '{3, 8'h08, 8'h07, 16'hFFFF, 1'b0, 0, 16'h017D, 8'h7F};
    tbl[2] = '{1, 8'h02, 8'h02, 16'h0000, 1'b0, 0, 16'hFFE0, NEG_E0};
    tbl[3] = '{0, 8'h00, 8'h00, 16'h0000, 1'b0, 0, 16'h0000, 8'h00};
    tbl[4] = '{5, 8'h08, 8'h07, 16'h0000, 1'b0, 0, 16'hFD85, NEG_80};
    tbl[5] = '{2, 8'h03, 8'h03, 16'h0FFF, 1'b0, 0, 16'h0030, 8'h30};
    tbl[6] = '{1, 8'h01, 8'h01, 16'hFFFF, 1'b1, 1, 16'h0010, 8'h10};
    tbl[7] = '{2, 8'h01, 8'h01, 16'hFFFF, 1'b1, 2, 16'h0020, 8'h20};
    tbl[8] = '{3, 8'h08, 8'h07, 16'hFFFF, 1'b1, 0, 16'h017D, 8'h7F};

    rst_ni = 1'b0; start_i = 1'b0; num_chunks_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; w_valid_i = 1'b0; w_bits_i = '0;
    out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("reset_ctrl_outputs",
          128'({in_ready_o, w_ready_o, out_valid_o, busy_o, mult_weights_o, out_data_o, out_acc_o}),
          128'(0));
    check("reset_mult_neurons", 128'(mult_neurons_o), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 0, $sformatf("vec%0d", i));

    // Result held under backpressure while start is pulsed.
    run_vec(tbl[0], 5, "hold");

    // Reset in the middle of a chunk, after 7 bytes.
    num_chunks_i = CW'(1);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(i + 1);
      w_valid_i  = (i == 0);
      w_bits_i   = 16'hA5C3;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    check("lane_packing", 128'(mult_neurons_o[55:0]), 128'(56'h07060504030201));
    check("weight_register", 128'(mult_weights_o), 128'(16'hA5C3));
    check("busy_mid_chunk", 128'({busy_o, in_ready_o}), 128'(2'b11));
    rst_ni = 1'b0;
    #1;
    check("async_reset_ctrl",
          128'({in_ready_o, w_ready_o, out_valid_o, busy_o, mult_weights_o, out_data_o, out_acc_o}),
          128'(0));
    check("async_reset_neurons", 128'(mult_neurons_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_vec(tbl[0], 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
